param_register_file: RTL and testbench
======================================

PARAM_REGISTER_FILE -- requirements
Module: param_register_file

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4, meaning register index width; NUM_REGS = 2**ADDR_W.
REQ-003 SHALL have parameter ZERO_REG0, default 0, meaning register 0 reads as 0 and ignores writes when set to 1.
REQ-004 SHALL have parameter BYPASS, default 1, meaning write-to-read forwarding is enabled when set to 1.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-007 SHALL have port SrcReg1, input, ADDR_W bits, read port 1 index.
REQ-008 SHALL have port SrcReg2, input, ADDR_W bits, read port 2 index.
REQ-009 SHALL have port DstReg, input, ADDR_W bits, write index.
REQ-010 SHALL have port WriteReg, input, 1 bit, write enable.
REQ-011 SHALL have port DstData, input, DATA_W bits, write data.
REQ-012 SHALL have port clear_req, input, 1 bit, single-cycle request to zero all registers.
REQ-013 SHALL have port SrcData1, output, DATA_W bits, read port 1 data (driven output, not inout).
REQ-014 SHALL have port SrcData2, output, DATA_W bits, read port 2 data.
REQ-015 SHALL have port busy, output, 1 bit, high while a clear sequence runs.

Function
REQ-016 SHALL store NUM_REGS registers of DATA_W bits each.
REQ-017 SHALL provide combinational reads: SrcDataN = reg[SrcRegN] in the same cycle, with 0 cycles of latency.
REQ-018 SHALL, when WriteReg=1 and busy=0, write DstData into reg[DstReg] at the rising clock edge.
REQ-019 SHALL, with BYPASS=1, WriteReg=1, busy=0 and SrcRegN==DstReg, drive SrcDataN = DstData in the same cycle; both ports may bypass at once.
REQ-020 SHALL, with BYPASS=0, return the pre-write stored value until the edge.
REQ-021 SHALL, with ZERO_REG0=1, read register 0 as 0 on both ports, ignore writes to it, and never bypass it.
REQ-022 SHALL implement a two-state FSM, IDLE and CLEAR, with an ADDR_W-bit clear counter.
REQ-023 SHALL, in IDLE with clear_req=1, go to CLEAR on the next edge with counter=0 and busy=1; a concurrent WriteReg in that same cycle still takes effect.
REQ-024 SHALL, in CLEAR, write 0 to reg[counter] each cycle and increment counter, one register per cycle.
REQ-025 SHALL, in CLEAR at counter==NUM_REGS-1, zero that register and return to IDLE with busy=0 on that edge, so busy is high for exactly NUM_REGS cycles.
REQ-026 SHALL, during CLEAR, ignore WriteReg (the write is dropped and no bypass occurs), while reads return current stored contents, partially cleared.
REQ-027 SHALL ignore clear_req while busy=1.
REQ-028 SHALL wrap the counter naturally; no index beyond NUM_REGS-1 is ever addressed.

Reset
REQ-029 SHALL, while rst=1, asynchronously force all registers to 0, the FSM to IDLE, the counter to 0 and busy to 0; SrcData1/2 then read 0, or the bypassed DstData if WriteReg=1 and BYPASS=1.
REQ-030 SHALL, on rst asserted mid-CLEAR, abort the sequence immediately, and SHALL resume normal operation on the first edge after rst deasserts.

Verification
REQ-031 SHALL cover: reset, then write 0xBEEF to r5 and read r5 on both ports the next cycle -> SrcData1=SrcData2=0xBEEF.
REQ-032 SHALL cover: WriteReg=1, DstReg=3, DstData=0x1234, SrcReg1=3, SrcReg2=4 in the same cycle -> SrcData1=0x1234 (BYPASS=1) or the old r3 value (BYPASS=0); SrcData2 = r4.
REQ-033 SHALL cover: ZERO_REG0=1, write 0xFFFF to r0 -> both ports read 0 in the write cycle and after it.
REQ-034 SHALL cover: fill all 16 registers nonzero, pulse clear_req -> busy high for exactly 16 cycles, r0..r15 read 0 afterwards, and a write issued at clear cycle 8 is dropped.
REQ-035 SHALL cover: rst asserted at clear cycle 5 -> busy=0 immediately, all registers 0, and a write on the first edge after rst deasserts lands.
REQ-036 SHALL cover: DATA_W=32, ADDR_W=5 -> 32 registers, 32-bit data, clear takes 32 cycles, and 0xDEADBEEF round-trips through r31.

Source files
------------

// File: rtl/param_register_file.sv
// Parameterised two-read/one-write register file with optional same-cycle write
// forwarding, an optional hardwired-zero register 0, and a one-register-per-cycle clear engine.
module param_register_file #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 4,
  parameter bit ZERO_REG0 = 1'b0,
  parameter bit BYPASS    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] SrcReg1,
  input  logic [ADDR_W-1:0] SrcReg2,
  input  logic [ADDR_W-1:0] DstReg,
  input  logic              WriteReg,
  input  logic [DATA_W-1:0] DstData,
  input  logic              clear_req,
  output logic [DATA_W-1:0] SrcData1,
  output logic [DATA_W-1:0] SrcData2,
  output logic              busy
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state_r;
  state_t            stateNext_s;
  logic [ADDR_W-1:0] clearCnt_r;
  logic [ADDR_W-1:0] clearCntNext_s;
  logic              busy_r;
  logic              writeEn_s;
  logic              dstIsZero_s;
  logic              src1IsZero_s;
  logic              src2IsZero_s;
  logic [DATA_W-1:0] regFile_r [NUM_REGS];

  // Hardwired-zero detection for register 0 on every index.
  always_comb begin
    dstIsZero_s  = ZERO_REG0 && (DstReg  == {ADDR_W{1'b0}});
    src1IsZero_s = ZERO_REG0 && (SrcReg1 == {ADDR_W{1'b0}});
    src2IsZero_s = ZERO_REG0 && (SrcReg2 == {ADDR_W{1'b0}});
  end

  // Writes are accepted only in IDLE; a write to a hardwired-zero register 0 is discarded.
  always_comb begin
    writeEn_s = WriteReg && (state_r == IDLE) && !dstIsZero_s;
  end

  // FSM next-state and clear-counter logic.
  always_comb begin
    stateNext_s    = state_r;
    clearCntNext_s = clearCnt_r;
    case (state_r)
      IDLE: begin
        if (clear_req) begin
          stateNext_s    = CLEAR;
          clearCntNext_s = {ADDR_W{1'b0}};
        end else begin
          stateNext_s    = IDLE;
        end
      end
      CLEAR: begin
        // The counter wraps back to zero on the final clear cycle.
        clearCntNext_s = clearCnt_r + ADDR_W'(1'b1);
        if (clearCnt_r == {ADDR_W{1'b1}}) begin
          stateNext_s = IDLE;
        end else begin
          stateNext_s = CLEAR;
        end
      end
      default: begin
        stateNext_s    = IDLE;
        clearCntNext_s = {ADDR_W{1'b0}};
      end
    endcase
  end

  // FSM state, clear counter and busy flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      clearCnt_r <= {ADDR_W{1'b0}};
      busy_r     <= 1'b0;
    end else begin
      state_r    <= stateNext_s;
      clearCnt_r <= clearCntNext_s;
      busy_r     <= (stateNext_s == CLEAR);
    end
  end

  // Register storage: clear engine has priority, user writes only when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regFile_r[i] <= {DATA_W{1'b0}};
      end
    end else if (state_r == CLEAR) begin
      regFile_r[clearCnt_r] <= {DATA_W{1'b0}};
    end else if (writeEn_s) begin
      regFile_r[DstReg] <= DstData;
    end
  end

  // Combinational read ports with optional forwarding of the in-flight write.
  always_comb begin
    if (src1IsZero_s) begin
      SrcData1 = {DATA_W{1'b0}};
    end else if (BYPASS && writeEn_s && (SrcReg1 == DstReg)) begin
      SrcData1 = DstData;
    end else begin
      SrcData1 = regFile_r[SrcReg1];
    end

    if (src2IsZero_s) begin
      SrcData2 = {DATA_W{1'b0}};
    end else if (BYPASS && writeEn_s && (SrcReg2 == DstReg)) begin
      SrcData2 = DstData;
    end else begin
      SrcData2 = regFile_r[SrcReg2];
    end
  end

  assign busy = busy_r;

endmodule

// File: tb/tb_param_register_file.sv
// Bench for param_register_file: three configurations (default, zero-reg0 without
// forwarding, 32x32) driven from a vector table plus hand-written clear/reset sequences.
module tb_param_register_file;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]  src1, src2, dst;
  logic        we, clr;
  logic [15:0] wd;
  logic [15:0] a1, a2, b1, b2;
  logic        aBusy, bBusy;

  logic [4:0]  cSrc1, cSrc2, cDst;
  logic        cWe, cClr;
  logic [31:0] cWd, c1, c2;
  logic        cBusy;

  param_register_file #(.DATA_W(16), .ADDR_W(4), .ZERO_REG0(1'b0), .BYPASS(1'b1)) dutA (
    .clk(clk), .rst(rst), .SrcReg1(src1), .SrcReg2(src2), .DstReg(dst), .WriteReg(we),
    .DstData(wd), .clear_req(clr), .SrcData1(a1), .SrcData2(a2), .busy(aBusy));

  param_register_file #(.DATA_W(16), .ADDR_W(4), .ZERO_REG0(1'b1), .BYPASS(1'b0)) dutB (
    .clk(clk), .rst(rst), .SrcReg1(src1), .SrcReg2(src2), .DstReg(dst), .WriteReg(we),
    .DstData(wd), .clear_req(clr), .SrcData1(b1), .SrcData2(b2), .busy(bBusy));

  param_register_file #(.DATA_W(32), .ADDR_W(5), .ZERO_REG0(1'b0), .BYPASS(1'b1)) dutC (
    .clk(clk), .rst(rst), .SrcReg1(cSrc1), .SrcReg2(cSrc2), .DstReg(cDst), .WriteReg(cWe),
    .DstData(cWd), .clear_req(cClr), .SrcData1(c1), .SrcData2(c2), .busy(cBusy));

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sbEntry_t;

  typedef struct {
    logic [3:0]  s1, s2, d;
    logic        w;
    logic [15:0] data;
    logic [15:0] ea1, ea2, eb1, eb2;
  } vec_t;

  sbEntry_t sbQ[$];
  vec_t     vecs[11];
  int       checks = 0;
  int       passed = 0;

  task automatic push(input string n, input logic [31:0] e);
    sbEntry_t s;
    s.name = n;
    s.exp  = e;
    sbQ.push_back(s);
  endtask

  task automatic pop(input logic [31:0] act);
    sbEntry_t s;
    checks++;
    if (sbQ.size() == 0) begin
      $display("FAIL scoreboard_empty: got %h with nothing expected", act);
    end else begin
      s = sbQ.pop_front();
      if (act === s.exp) passed++;
      else $display("FAIL %s: got %h, want %h", s.name, act, s.exp);
    end
  endtask

  task automatic checkAB(input string tag, input logic [15:0] ea1, input logic [15:0] ea2,
                         input logic [15:0] eb1, input logic [15:0] eb2);
    push({tag, ".A1"}, {16'h0, ea1});
    push({tag, ".A2"}, {16'h0, ea2});
    push({tag, ".B1"}, {16'h0, eb1});
    push({tag, ".B2"}, {16'h0, eb2});
    #1;
    pop({16'h0, a1});
    pop({16'h0, a2});
    pop({16'h0, b1});
    pop({16'h0, b2});
  endtask

  task automatic checkBusy(input string tag, input logic e);
    push({tag, ".busyA"}, {31'h0, e});
    push({tag, ".busyB"}, {31'h0, e});
    #1;
    pop({31'h0, aBusy});
    pop({31'h0, bBusy});
  endtask

  function automatic logic [15:0] fillVal(input int i);
    return 16'hA000 | 16'(i);
  endfunction

  // Writes fillVal(i) into every register of A and B; returns at a negedge with we low.
  task automatic fillAB();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      we = 1'b1; dst = i[3:0]; wd = fillVal(i);
    end
    @(negedge clk);
    we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busyCnt;

    rst = 1'b1; src1 = 4'd0; src2 = 4'd0; dst = 4'd0; we = 1'b0; clr = 1'b0; wd = 16'h0;
    cSrc1 = 5'd0; cSrc2 = 5'd0; cDst = 5'd0; cWe = 1'b0; cClr = 1'b0; cWd = 32'h0;

    vecs[0]  = '{4'd5,  4'd5,  4'd5,  1'b1, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'h0000, 16'h0000};
    vecs[1]  = '{4'd5,  4'd5,  4'd0,  1'b0, 16'h0000, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF};
    vecs[2]  = '{4'd4,  4'd5,  4'd4,  1'b1, 16'h5555, 16'h5555, 16'hBEEF, 16'h0000, 16'hBEEF};
    vecs[3]  = '{4'd3,  4'd4,  4'd3,  1'b1, 16'h1234, 16'h1234, 16'h5555, 16'h0000, 16'h5555};
    vecs[4]  = '{4'd3,  4'd0,  4'd0,  1'b0, 16'h0000, 16'h1234, 16'h0000, 16'h1234, 16'h0000};
    vecs[5]  = '{4'd0,  4'd0,  4'd0,  1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000};
    vecs[6]  = '{4'd0,  4'd3,  4'd0,  1'b0, 16'h0000, 16'hFFFF, 16'h1234, 16'h0000, 16'h1234};
    vecs[7]  = '{4'd7,  4'd7,  4'd7,  1'b1, 16'h00A5, 16'h00A5, 16'h00A5, 16'h0000, 16'h0000};
    vecs[8]  = '{4'd7,  4'd15, 4'd0,  1'b0, 16'h0000, 16'h00A5, 16'h0000, 16'h00A5, 16'h0000};
    vecs[9]  = '{4'd15, 4'd0,  4'd15, 1'b1, 16'h8001, 16'h8001, 16'hFFFF, 16'h0000, 16'h0000};
    vecs[10] = '{4'd15, 4'd15, 4'd0,  1'b0, 16'h0000, 16'h8001, 16'h8001, 16'h8001, 16'h8001};

    // Reset state
    #1;
    checkAB("reset", 16'h0, 16'h0, 16'h0, 16'h0);
    checkBusy("reset", 1'b0);
    push("reset.C1", 32'h0); push("reset.busyC", 32'h0);
    #1;
    pop(c1); pop({31'h0, cBusy});
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven read/write/bypass/zero-reg vectors
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      src1 = vecs[i].s1; src2 = vecs[i].s2; dst = vecs[i].d; we = vecs[i].w; wd = vecs[i].data;
      checkAB($sformatf("vec%0d", i), vecs[i].ea1, vecs[i].ea2, vecs[i].eb1, vecs[i].eb2);
      checkBusy($sformatf("vec%0d", i), 1'b0);
    end
    @(negedge clk);
    we = 1'b0;

    // Full clear sequence with a concurrent write on the request cycle and a dropped one mid-clear
    fillAB();
    clr = 1'b1; we = 1'b1; dst = 4'd2; wd = 16'h2222;
    checkBusy("clrReq", 1'b0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      clr = 1'b0; we = 1'b0;
      if (k == 0) begin
        src1 = 4'd2; src2 = 4'd0;
        checkAB("clr0", 16'h2222, fillVal(0), 16'h2222, 16'h0000);
      end else if (k == 8) begin
        we = 1'b1; dst = 4'd12; wd = 16'h7777; src1 = 4'd12; src2 = 4'd7;
        checkAB("clr8", fillVal(12), 16'h0000, fillVal(12), 16'h0000);
      end else if (k == 9) begin
        clr = 1'b1; src1 = 4'd12; src2 = 4'd8;
        checkAB("clr9", fillVal(12), 16'h0000, fillVal(12), 16'h0000);
      end
      checkBusy($sformatf("clrCyc%0d", k), 1'b1);
    end
    @(negedge clk);
    checkBusy("clrDone", 1'b0);
    for (int i = 0; i < 16; i++) begin
      src1 = i[3:0]; src2 = 4'(15 - i);
      checkAB($sformatf("cleared%0d", i), 16'h0, 16'h0, 16'h0, 16'h0);
    end
    @(negedge clk);
    checkBusy("clrIgnored", 1'b0);

    // Reset asserted in clear cycle 5
    fillAB();
    clr = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      clr = 1'b0;
    end
    checkBusy("preRst", 1'b1);
    rst = 1'b1;
    #1;
    checkBusy("rstMid", 1'b0);
    src1 = 4'd10; src2 = 4'd14;
    checkAB("rstRead", 16'h0, 16'h0, 16'h0, 16'h0);
    we = 1'b1; dst = 4'd6; wd = 16'h6666; src1 = 4'd6;
    checkAB("rstBypass", 16'h6666, 16'h0, 16'h0, 16'h0);
    we = 1'b0;
    for (int i = 0; i < 16; i++) begin
      src1 = i[3:0]; src2 = 4'(15 - i);
      checkAB($sformatf("rstZero%0d", i), 16'h0, 16'h0, 16'h0, 16'h0);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    we = 1'b1; dst = 4'd9; wd = 16'h9999; src1 = 4'd9; src2 = 4'd9;
    checkAB("postRstWr", 16'h9999, 16'h9999, 16'h0, 16'h0);
    @(negedge clk);
    we = 1'b0;
    checkAB("postRstRd", 16'h9999, 16'h9999, 16'h9999, 16'h9999);
    checkBusy("postRst", 1'b0);

    // 32x32 configuration: round-trip through r31 and a 32-cycle clear
    @(negedge clk);
    cWe = 1'b1; cDst = 5'd31; cWd = 32'hDEADBEEF; cSrc1 = 5'd31; cSrc2 = 5'd30;
    push("c.bypass1", 32'hDEADBEEF); push("c.bypass2", 32'h0);
    #1;
    pop(c1); pop(c2);
    @(negedge clk);
    cWe = 1'b0; cSrc2 = 5'd31;
    push("c.r31p1", 32'hDEADBEEF); push("c.r31p2", 32'hDEADBEEF);
    #1;
    pop(c1); pop(c2);
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      cWe = 1'b1; cDst = i[4:0]; cWd = 32'h1000_0000 | 32'(i);
    end
    @(negedge clk);
    cWe = 1'b0; cClr = 1'b1;
    @(negedge clk);
    cClr = 1'b0;
    busyCnt = 0;
    for (int t = 0; t < 100; t++) begin
      #2;
      if (!cBusy) break;
      busyCnt++;
      @(negedge clk);
    end
    push("c.clearCycles", 32'd32);
    pop(32'(busyCnt));
    for (int i = 0; i < 32; i++) begin
      cSrc1 = i[4:0]; cSrc2 = 5'(31 - i);
      push($sformatf("c.cleared%0d.1", i), 32'h0); push($sformatf("c.cleared%0d.2", i), 32'h0);
      #1;
      pop(c1); pop(c2);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
